max_unpool2d: RTL
=================

Name: max_unpool2d

Overview:
- Inverse of the 2x2/stride-2 max-pool stage. Consumes a stream of pooled values, each with its 2-bit argmax position, and emits the upsampled map stream (CHANNELS x 2*IN_H x 2*IN_W) in raster order.
- Sits in the decoder/visualisation path, and in the backward path for gradient routing.
- Uses a single-row buffer so that output is strictly raster order, with valid/ready on both sides and a start/done frame handshake.

Parameters:
DATA_W, 32, signed sample width
CHANNELS, 16, feature maps per frame
IN_H, 14, pooled rows per map
IN_W, 14, pooled columns per map
MODE, 0, 0 = max-unpool (value at argmax, zeros elsewhere); 1 = nearest replicate (value in all 4 positions, idx ignored)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin one frame; sampled only in IDLE
done  out  1  one-cycle pulse after final output beat
in_valid  in  1  input beat valid
in_ready  out  1  block accepts input beat
in_data  in  DATA_W  pooled value, signed
in_idx  in  2  argmax: bit1 = row offset (0 top, 1 bottom), bit0 = col offset (0 left, 1 right)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_data  out  DATA_W  unpooled value, signed
out_last  out  1  high on final beat of the frame (f=CHANNELS-1, r=2*IN_H-1, c=2*IN_W-1)

Behaviour:
- Transfers: a transfer occurs on a rising edge with valid&&ready. out_data and out_last are held stable while out_valid && !out_ready.
- Reset (reset==0 at an edge):
  - State = IDLE; all counters (f, i, j, sub, bot_col) = 0; hold_valid = 0.
  - done = 0, in_ready = 0, out_valid = 0, out_last = 0, out_data = 0.
  - Row buffer contents are don't-care.
  - Reset mid-frame aborts the frame. Partial output is not flushed.
- State IDLE: start==1 goes to TOP with f=i=j=0. start in any other state is ignored.
- State TOP, top output row r=2i:
  - in_ready = !hold_valid || (sub==1 && out_ready).
  - On an input transfer: capture in_data/in_idx into the hold register and into row_buf[j]; set sub=0; j advances.
  - While hold_valid: out_valid=1 and emits col c=2j+sub.
    - MODE 0: out_data = hold_data if in_idx==={0,sub}, else 0.
    - MODE 1: out_data = hold_data.
  - An output transfer with sub==0 sets sub=1. An output transfer with sub==1 clears hold_valid, unless a new input is accepted in the same cycle.
  - Sustained rate: 1 input per 2 output beats, no bubbles when both sides are ready.
  - After the output transfer for c=2*IN_W-1, go to BOT with bot_col=0.
- State BOT, bottom output row r=2i+1:
  - in_ready=0; out_valid=1.
  - out_data is taken from row_buf[bot_col>>1].
    - MODE 0: the value if stored idx==={1,bot_col[0]}, else 0.
    - MODE 1: always the value.
  - bot_col increments per output transfer.
  - After bot_col=2*IN_W-1 transfers:
    - i<IN_H-1: i++, j=0, go to TOP.
    - else i=0 and, if f<CHANNELS-1: f++, go to TOP.
    - else (last beat, out_last=1): go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE.
- Latency: the first output beat (out_valid) appears the cycle after the first input transfer. Output uses registered state only; there is no combinational in->out path except through in_ready.
- Arithmetic: no arithmetic on data. Zero fill is a signed 0. Values pass through bit-exact, including the most-negative value 0x80000000.
- Counters: sized by $clog2 of (max value+1). No wrap-around beyond the stated limits; all index compares are exact equality to the limits.
- Frame size: exactly CHANNELS*IN_H*IN_W input beats and 4x that many output beats. Inputs beyond the frame are never accepted (in_ready=0 outside TOP).

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with start=1 -> done, in_ready, out_valid, out_last all 0; after release without start, the block stays IDLE with in_ready=0.
- MODE 0, single pixel pattern: first input 0x00000007 with idx=2'b10, others 0 with idx=0 -> map 0 out(1,0)=7; out(0,0), out(0,1), out(1,1)=0; the pair (0,0),(0,1) appears before the first-row beats of column pair 1.
- MODE 0, full frame with random idx, out_ready=1 -> exactly 12544 output beats matching the golden model; out_last only on beat 12543; done pulses the cycle after it; input transfers 3136.
- MODE 1, value 0xFFFFFFF6 (-10) at pooled (0,0) -> out (0,0),(0,1),(1,0),(1,1) = -10; idx ignored.
- Backpressure: random out_ready (50%) and in_valid gaps -> data stable while stalled, no lost or duplicated beats, in_ready=0 throughout every BOT row.
- Reset mid-frame after 100 output beats, then start again -> the new frame restarts at f=i=j=0, its first output is (0,0) of the new data, and the count is exactly 12544.

Source files
------------

// File: rtl/max_unpool2d.sv
// 2x2/stride-2 max-unpool (or nearest-replicate) with a single-row buffer.
// Input beats fill the top output row directly; the bottom row is replayed from the buffer.
module max_unpool2d #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned IN_H     = 14,
  parameter int unsigned IN_W     = 14,
  parameter int unsigned MODE     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned FW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned HW   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned BW   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned JW   = $clog2(IN_W + 1);
  localparam int unsigned ColW = $clog2(2 * IN_W);

  localparam logic [FW-1:0]   FLast   = FW'(CHANNELS - 1);
  localparam logic [HW-1:0]   ILast   = HW'(IN_H - 1);
  localparam logic [JW-1:0]   JFull   = JW'(IN_W);
  localparam logic [ColW-1:0] ColLast = ColW'(2 * IN_W - 1);

  typedef enum logic [1:0] {StIdle, StTop, StBot, StDone} state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       f_q, f_d;
  logic [HW-1:0]       i_q, i_d;
  logic [JW-1:0]       j_q, j_d;
  logic [ColW-1:0]     col_q, col_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [1:0]          hold_idx_q, hold_idx_d;

  logic [DATA_W-1:0]   buf_data_q [IN_W];
  logic [1:0]          buf_idx_q  [IN_W];

  logic                in_fire, out_fire;
  logic [BW-1:0]       wr_idx, rd_idx;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wr_idx   = j_q[BW-1:0];
  assign rd_idx   = BW'(col_q >> 1);

  // Outputs depend only on registered state, except in_ready which looks at out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StTop: begin
        // col_q[0] is the sub-column of the held pixel; a new pixel may enter on its last beat.
        in_ready  = (j_q != JFull) && (!hold_valid_q || (col_q[0] && out_ready));
        out_valid = hold_valid_q;
        if (hold_valid_q && (MODE == 1 || hold_idx_q == {1'b0, col_q[0]})) begin
          out_data = hold_data_q;
        end
      end
      StBot: begin
        out_valid = 1'b1;
        if (MODE == 1 || buf_idx_q[rd_idx] == {1'b1, col_q[0]}) begin
          out_data = buf_data_q[rd_idx];
        end
        out_last = (f_q == FLast) && (i_q == ILast) && (col_q == ColLast);
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    f_d          = f_q;
    i_d          = i_q;
    j_d          = j_q;
    col_d        = col_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_idx_d   = hold_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StTop;
          f_d          = '0;
          i_d          = '0;
          j_d          = '0;
          col_d        = '0;
          hold_valid_d = 1'b0;
        end
      end
      StTop: begin
        if (out_fire) begin
          col_d = col_q + ColW'(1);
          if (col_q[0]) hold_valid_d = 1'b0;
        end
        if (in_fire) begin
          hold_valid_d = 1'b1;
          hold_data_d  = in_data;
          hold_idx_d   = in_idx;
          j_d          = j_q + JW'(1);
        end
        if (out_fire && col_q == ColLast) begin
          state_d = StBot;
          col_d   = '0;
          j_d     = '0;
        end
      end
      StBot: begin
        if (out_fire) begin
          col_d = col_q + ColW'(1);
          if (col_q == ColLast) begin
            col_d = '0;
            if (i_q != ILast) begin
              i_d     = i_q + HW'(1);
              state_d = StTop;
            end else begin
              i_d = '0;
              if (f_q != FLast) begin
                f_d     = f_q + FW'(1);
                state_d = StTop;
              end else begin
                f_d     = '0;
                state_d = StDone;
              end
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      f_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      col_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      f_q          <= f_d;
      i_q          <= i_d;
      j_q          <= j_d;
      col_q        <= col_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_idx_q   <= hold_idx_d;
    end
  end

  // Row buffer holds the top row's pixels for the bottom-row replay; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_data_q[wr_idx] <= in_data;
      buf_idx_q[wr_idx]  <= in_idx;
    end
  end

endmodule
